// File: rtl/pkg_filtros.sv
// rtl/pkg_filtros.sv - shared constants and state encoding for the filter pipeline
// Purpose: row geometry constants and the window-generator state type, also
//          used by the downstream comparator stages.
// Ports:   none (package).
package pkg_filtros;

  localparam int ANCHO_FILA     = 64;
  localparam int ANCHO_PIXEL    = 8;
  localparam int NUM_FILAS      = 5;
  localparam int NUM_POSICIONES = 4;

  typedef enum logic {
    CARGA   = 1'b0,
    BARRIDO = 1'b1
  } estado_t;

endpackage

// File: rtl/banco_filas.sv
// rtl/banco_filas.sv - five-row sliding shift register
// Purpose: holds the last five accepted rows; a load shifts every row up by
//          one and places the new row at the bottom.
// Ports:   clk, reset_n (sync, active-low), carga (shift enable),
//          dato (new row), fila_1 (oldest) .. fila_5 (newest).
module banco_filas
  import pkg_filtros::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  carga,
  input  logic [ANCHO_FILA-1:0] dato,
  output logic [ANCHO_FILA-1:0] fila_1,
  output logic [ANCHO_FILA-1:0] fila_2,
  output logic [ANCHO_FILA-1:0] fila_3,
  output logic [ANCHO_FILA-1:0] fila_4,
  output logic [ANCHO_FILA-1:0] fila_5
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fila_1 <= '0;
      fila_2 <= '0;
      fila_3 <= '0;
      fila_4 <= '0;
      fila_5 <= '0;
    end else if (carga) begin
      fila_1 <= fila_2;
      fila_2 <= fila_3;
      fila_3 <= fila_4;
      fila_4 <= fila_5;
      fila_5 <= dato;
    end
  end

endmodule

// File: rtl/generador_ventanas_filas.sv
// rtl/generador_ventanas_filas.sv - 5-row window generator with horizontal sweep
// Purpose: buffers the last five image rows and, once five are present, holds
//          them while sweeping seleccion 0..3 for the row-max comparator.
// Ports:   clk, reset_n (sync, active-low); datos_entrada/entrada_valida/
//          entrada_lista (row input handshake); fila_1..fila_5, seleccion,
//          ventana_valida, salida_lista (window output handshake);
//          fin_cuadro (one-cycle pulse after the last window of a frame).
module generador_ventanas_filas #(
  parameter int ALTO       = 480,
  parameter int ANCHO_FILA = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ANCHO_FILA-1:0] datos_entrada,
  input  logic                  entrada_valida,
  output logic                  entrada_lista,
  output logic [ANCHO_FILA-1:0] fila_1,
  output logic [ANCHO_FILA-1:0] fila_2,
  output logic [ANCHO_FILA-1:0] fila_3,
  output logic [ANCHO_FILA-1:0] fila_4,
  output logic [ANCHO_FILA-1:0] fila_5,
  output logic [1:0]            seleccion,
  output logic                  ventana_valida,
  input  logic                  salida_lista,
  output logic                  fin_cuadro
);

  localparam int ANCHO_CONT = $clog2(ALTO);
  localparam logic [2:0] LLENO = 3'(pkg_filtros::NUM_FILAS);
  localparam logic [1:0] ULTIMA_POS = 2'(pkg_filtros::NUM_POSICIONES - 1);
  localparam logic [ANCHO_CONT-1:0] ULTIMA_FILA = ANCHO_CONT'(ALTO - 1);

  pkg_filtros::estado_t  estado;
  logic [2:0]            llenado;
  logic [ANCHO_CONT-1:0] contador_filas;
  // Remembers that the sweep in progress was triggered by the frame's last row.
  logic                  fin_pendiente;
  logic                  acepta;

  assign entrada_lista = (estado == pkg_filtros::CARGA);
  assign acepta        = entrada_valida && entrada_lista;

  banco_filas u_banco_filas (
    .clk     (clk),
    .reset_n (reset_n),
    .carga   (acepta),
    .dato    (datos_entrada),
    .fila_1  (fila_1),
    .fila_2  (fila_2),
    .fila_3  (fila_3),
    .fila_4  (fila_4),
    .fila_5  (fila_5)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado         <= pkg_filtros::CARGA;
      llenado        <= 3'd0;
      contador_filas <= '0;
      seleccion      <= 2'd0;
      ventana_valida <= 1'b0;
      fin_cuadro     <= 1'b0;
      fin_pendiente  <= 1'b0;
    end else begin
      fin_cuadro <= 1'b0;
      case (estado)
        pkg_filtros::CARGA: begin
          if (acepta) begin
            contador_filas <= contador_filas + ANCHO_CONT'(1);
            if (llenado != LLENO) begin
              llenado <= llenado + 3'd1;
            end
            // This accept brings the buffer to five rows: start a sweep.
            if (llenado >= LLENO - 3'd1) begin
              estado         <= pkg_filtros::BARRIDO;
              ventana_valida <= 1'b1;
              seleccion      <= 2'd0;
              fin_pendiente  <= (contador_filas == ULTIMA_FILA);
            end
          end
        end
        pkg_filtros::BARRIDO: begin
          if (salida_lista) begin
            if (seleccion == ULTIMA_POS) begin
              seleccion      <= 2'd0;
              ventana_valida <= 1'b0;
              estado         <= pkg_filtros::CARGA;
              if (fin_pendiente) begin
                // Rows stay in the bank; llenado restarting keeps them unflagged.
                llenado        <= 3'd0;
                contador_filas <= '0;
                fin_cuadro     <= 1'b1;
                fin_pendiente  <= 1'b0;
              end
            end else begin
              seleccion <= seleccion + 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generador_ventanas_filas.sv
// tb/tb_generador_ventanas_filas.sv - self-checking bench for generador_ventanas_filas
module tb_generador_ventanas_filas;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] datos_entrada;
  logic        entrada_valida;
  logic        entrada_lista;
  logic [63:0] fila_1, fila_2, fila_3, fila_4, fila_5;
  logic [1:0]  seleccion;
  logic        ventana_valida;
  logic        salida_lista;
  logic        fin_cuadro;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  generador_ventanas_filas #(.ALTO(6), .ANCHO_FILA(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .datos_entrada  (datos_entrada),
    .entrada_valida (entrada_valida),
    .entrada_lista  (entrada_lista),
    .fila_1         (fila_1),
    .fila_2         (fila_2),
    .fila_3         (fila_3),
    .fila_4         (fila_4),
    .fila_5         (fila_5),
    .seleccion      (seleccion),
    .ventana_valida (ventana_valida),
    .salida_lista   (salida_lista),
    .fin_cuadro     (fin_cuadro)
  );

  typedef struct {
    logic       rst_n;
    logic       ev;
    logic [7:0] dk;
    logic       sl;
    logic       vv;
    logic [1:0] sel;
    logic       el;
    logic [7:0] f1k;
    logic [7:0] f3k;
    logic [7:0] f5k;
    logic       fin;
  } vec_t;

  vec_t vecs[31];

  function automatic logic [63:0] fila_de(input logic [7:0] k);
    return {8{k}};
  endfunction

  task automatic chk(input string nombre, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h expected %h", nombre, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_vv, n_fin, ult_vv, ciclo_fin, cnt;

    //               rst ev  dk     sl  vv sel el  f1     f3     f5     fin
    vecs[0]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 2'd0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 2'd0, 1'b1, 8'h00, 8'h00, 8'h02, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 2'd0, 1'b1, 8'h00, 8'h01, 8'h03, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 2'd0, 1'b1, 8'h00, 8'h02, 8'h04, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 2'd0, 1'b0, 8'h01, 8'h03, 8'h05, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b0, 8'h01, 8'h03, 8'h05, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b0, 8'h01, 8'h03, 8'h05, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 1'b0, 8'h01, 8'h03, 8'h05, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 8'h01, 8'h03, 8'h05, 1'b0};
    // sliding: sixth row (last row of a 6-row frame)
    vecs[9]  = '{1'b1, 1'b1, 8'h06, 1'b1, 1'b1, 2'd0, 1'b0, 8'h02, 8'h04, 8'h06, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b0, 8'h02, 8'h04, 8'h06, 1'b0};
    // stall at seleccion 1 with an illegal row offered meanwhile
    vecs[11] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 2'd1, 1'b0, 8'h02, 8'h04, 8'h06, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 2'd1, 1'b0, 8'h02, 8'h04, 8'h06, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 2'd1, 1'b0, 8'h02, 8'h04, 8'h06, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b0, 8'h02, 8'h04, 8'h06, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 1'b0, 8'h02, 8'h04, 8'h06, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 8'h02, 8'h04, 8'h06, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 8'h02, 8'h04, 8'h06, 1'b0};
    // new frame: four rows without windows, fifth starts a sweep
    vecs[18] = '{1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 2'd0, 1'b1, 8'h03, 8'h05, 8'h07, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 8'h08, 1'b1, 1'b0, 2'd0, 1'b1, 8'h04, 8'h06, 8'h08, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 8'h09, 1'b1, 1'b0, 2'd0, 1'b1, 8'h05, 8'h07, 8'h09, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 8'h0A, 1'b1, 1'b0, 2'd0, 1'b1, 8'h06, 8'h08, 8'h0A, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 8'h0B, 1'b1, 1'b1, 2'd0, 1'b0, 8'h07, 8'h09, 8'h0B, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b0, 8'h07, 8'h09, 8'h0B, 1'b0};
    vecs[24] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b0, 8'h07, 8'h09, 8'h0B, 1'b0};
    // reset in the middle of the sweep
    vecs[25] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[26] = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 2'd0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0};
    vecs[27] = '{1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 2'd0, 1'b1, 8'h00, 8'h00, 8'h02, 1'b0};
    vecs[28] = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 2'd0, 1'b1, 8'h00, 8'h01, 8'h03, 1'b0};
    vecs[29] = '{1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 2'd0, 1'b1, 8'h00, 8'h02, 8'h04, 1'b0};
    vecs[30] = '{1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 2'd0, 1'b0, 8'h01, 8'h03, 8'h05, 1'b0};

    reset_n        = 1'b0;
    entrada_valida = 1'b0;
    datos_entrada  = '0;
    salida_lista   = 1'b1;
    repeat (2) tick();

    chk("reset_ventana_valida", -1, 64'(ventana_valida), 64'd0);
    chk("reset_seleccion",      -1, 64'(seleccion),      64'd0);
    chk("reset_entrada_lista",  -1, 64'(entrada_lista),  64'd1);
    chk("reset_fin_cuadro",     -1, 64'(fin_cuadro),     64'd0);
    chk("reset_fila_1",         -1, fila_1,              64'd0);
    chk("reset_fila_5",         -1, fila_5,              64'd0);

    reset_n = 1'b1;
    for (int i = 0; i < 31; i++) begin
      reset_n        = vecs[i].rst_n;
      entrada_valida = vecs[i].ev;
      datos_entrada  = fila_de(vecs[i].dk);
      salida_lista   = vecs[i].sl;
      tick();
      chk("ventana_valida", i, 64'(ventana_valida), 64'(vecs[i].vv));
      chk("seleccion",      i, 64'(seleccion),      64'(vecs[i].sel));
      chk("entrada_lista",  i, 64'(entrada_lista),  64'(vecs[i].el));
      chk("fila_1",         i, fila_1,              fila_de(vecs[i].f1k));
      chk("fila_3",         i, fila_3,              fila_de(vecs[i].f3k));
      chk("fila_5",         i, fila_5,              fila_de(vecs[i].f5k));
      chk("fin_cuadro",     i, 64'(fin_cuadro),     64'(vecs[i].fin));
    end
    chk("fila_2_lleno", 31, fila_2, fila_de(8'h02));
    chk("fila_4_lleno", 31, fila_4, fila_de(8'h04));

    // Sweep with salida_lista held high: positions 0..3 on consecutive cycles.
    entrada_valida = 1'b0;
    salida_lista   = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (ventana_valida) begin
        chk("barrido_seleccion", i, 64'(seleccion), 64'(cnt));
        cnt++;
      end
      tick();
    end
    chk("barrido_ventanas", 0, 64'(cnt), 64'd4);

    // Last row of the frame: four windows, then one fin_cuadro pulse right after.
    chk("lista_para_fila_6", 0, 64'(entrada_lista), 64'd1);
    entrada_valida = 1'b1;
    datos_entrada  = fila_de(8'h06);
    tick();
    entrada_valida = 1'b0;
    n_vv = 0; n_fin = 0; ult_vv = -10; ciclo_fin = -20;
    for (int i = 0; i < 12; i++) begin
      if (ventana_valida) begin
        n_vv++;
        ult_vv = i;
      end
      if (fin_cuadro) begin
        n_fin++;
        ciclo_fin = i;
      end
      tick();
    end
    chk("cuadro_ventanas",   1, 64'(n_vv),      64'd4);
    chk("cuadro_pulsos_fin", 1, 64'(n_fin),     64'd1);
    chk("cuadro_ciclo_fin",  1, 64'(ciclo_fin), 64'(ult_vv + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
